// File: rtl/bram_tdp_scoreboard.sv
// Shadow-memory scoreboard for a true-dual-port BRAM: flags read data that disagrees with the last write.
// Optional macro BRAM_SB_TRANSPARENT_EN also checks write-first read data on non-colliding writes.
module bram_tdp_scoreboard #(
    parameter int ABITS = 10,
    parameter int DBITS = 36,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ABITS-1:0] a_a,
    input  logic [ABITS-1:0] a_b,
    input  logic [DBITS-1:0] wd_a,
    input  logic [DBITS-1:0] wd_b,
    input  logic             we_a,
    input  logic             we_b,
    input  logic [DBITS-1:0] rd_a,
    input  logic [DBITS-1:0] rd_b,
    output logic             err_a,
    output logic             err_b,
    output logic             coll,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] chk_cnt
);
    localparam int DEPTH = 1 << ABITS;

    logic [DBITS-1:0] mem [DEPTH];
    logic             vld [DEPTH];

    logic             coll_now;
    logic             blk_a, blk_b;
    logic             arm_a, arm_b;
    logic [DBITS-1:0] exp_a_next, exp_b_next;
    logic [DBITS-1:0] exp_a_reg, exp_b_reg;
    logic             pend_a_reg, pend_b_reg;
    logic             mis_a, mis_b;
    logic [1:0]       chk_inc, err_inc;

    logic             err_a_reg, err_b_reg, coll_reg, err_sticky_reg;
    logic [CNT_W-1:0] err_cnt_reg, chk_cnt_reg;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, c} + (CNT_W+1)'(inc);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // A port is blocked when the opposite port writes the same word this cycle.
    assign coll_now = we_a & we_b & (a_a == a_b);
    assign blk_a    = we_b & (a_b == a_a);
    assign blk_b    = we_a & (a_a == a_b);

`ifdef BRAM_SB_TRANSPARENT_EN
    assign arm_a      = ~blk_a & (we_a | vld[a_a]);
    assign arm_b      = ~blk_b & (we_b | vld[a_b]);
    assign exp_a_next = we_a ? wd_a : mem[a_a];
    assign exp_b_next = we_b ? wd_b : mem[a_b];
`else
    assign arm_a      = ~blk_a & ~we_a & vld[a_a];
    assign arm_b      = ~blk_b & ~we_b & vld[a_b];
    assign exp_a_next = mem[a_a];
    assign exp_b_next = mem[a_b];
`endif

    // Shadow contents and expected-data capture; contents need no reset since vld gates them.
    always_ff @(posedge clk) begin
        exp_a_reg <= exp_a_next;
        exp_b_reg <= exp_b_next;
        if (we_a && !coll_now) mem[a_a] <= wd_a;
        if (we_b && !coll_now) mem[a_b] <= wd_b;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_vld
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    vld[gi] <= 1'b0;
                else if (coll_now && (a_a == ABITS'(gi)))
                    vld[gi] <= 1'b0;
                else if ((we_a && (a_a == ABITS'(gi))) || (we_b && (a_b == ABITS'(gi))))
                    vld[gi] <= 1'b1;
            end
        end
    endgenerate

    assign mis_a   = pend_a_reg & (rd_a != exp_a_reg);
    assign mis_b   = pend_b_reg & (rd_b != exp_b_reg);
    assign chk_inc = {1'b0, pend_a_reg} + {1'b0, pend_b_reg};
    assign err_inc = {1'b0, mis_a} + {1'b0, mis_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_a_reg     <= 1'b0;
            pend_b_reg     <= 1'b0;
            err_a_reg      <= 1'b0;
            err_b_reg      <= 1'b0;
            coll_reg       <= 1'b0;
            err_sticky_reg <= 1'b0;
            err_cnt_reg    <= '0;
            chk_cnt_reg    <= '0;
        end else begin
            pend_a_reg     <= arm_a;
            pend_b_reg     <= arm_b;
            err_a_reg      <= mis_a;
            err_b_reg      <= mis_b;
            coll_reg       <= coll_now;
            err_sticky_reg <= err_sticky_reg | mis_a | mis_b;
            err_cnt_reg    <= sat_add(err_cnt_reg, err_inc);
            chk_cnt_reg    <= sat_add(chk_cnt_reg, chk_inc);
        end
    end

    assign err_a      = err_a_reg;
    assign err_b      = err_b_reg;
    assign coll       = coll_reg;
    assign err_sticky = err_sticky_reg;
    assign err_cnt    = err_cnt_reg;
    assign chk_cnt    = chk_cnt_reg;

endmodule

// File: tb/tb_bram_tdp_scoreboard.sv
// Bench for bram_tdp_scoreboard: directed scenarios plus random traffic against a shadow-memory model.
module tb_bram_tdp_scoreboard;
    localparam logic [9:0] IDLE_ADR = 10'h200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  a_a = IDLE_ADR, a_b = IDLE_ADR;
    logic [35:0] wd_a = '0, wd_b = '0, rd_a = '0, rd_b = '0;
    logic        we_a = 1'b0, we_b = 1'b0;

    logic        err_a, err_b, coll, err_sticky;
    logic [15:0] err_cnt, chk_cnt;
    logic        s_err_a, s_err_b, s_coll, s_sticky;
    logic [3:0]  s_err_cnt, s_chk_cnt;

    always #5 clk = ~clk;

    bram_tdp_scoreboard #(.ABITS(10), .DBITS(36), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .a_a(a_a), .a_b(a_b), .wd_a(wd_a), .wd_b(wd_b),
        .we_a(we_a), .we_b(we_b), .rd_a(rd_a), .rd_b(rd_b),
        .err_a(err_a), .err_b(err_b), .coll(coll), .err_sticky(err_sticky),
        .err_cnt(err_cnt), .chk_cnt(chk_cnt)
    );

    // Narrow-counter instance on the same traffic, to observe saturation.
    bram_tdp_scoreboard #(.ABITS(10), .DBITS(36), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .a_a(a_a), .a_b(a_b), .wd_a(wd_a), .wd_b(wd_b),
        .we_a(we_a), .we_b(we_b), .rd_a(rd_a), .rd_b(rd_b),
        .err_a(s_err_a), .err_b(s_err_b), .coll(s_coll), .err_sticky(s_sticky),
        .err_cnt(s_err_cnt), .chk_cnt(s_chk_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: what the scoreboard knows about memory and which reads await data.
    logic [35:0] sh_mem [1024];
    bit          sh_vld [1024];
    bit          m_pend_a, m_pend_b;
    logic [35:0] m_exp_a, m_exp_b;
    longint      n_chk, n_err;
    bit          m_sticky, m_err_a, m_err_b, m_coll;

    function automatic logic [35:0] rand36();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[35:0];
    endfunction

    function automatic longint sat(input longint n, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) sh_vld[i] = 1'b0;
        m_pend_a = 0; m_pend_b = 0;
        n_chk = 0; n_err = 0;
        m_sticky = 0; m_err_a = 0; m_err_b = 0; m_coll = 0;
    endtask

    task automatic check_outputs(input string where);
        check({where, ".err_a"}, err_a, m_err_a);
        check({where, ".err_b"}, err_b, m_err_b);
        check({where, ".coll"}, coll, m_coll);
        check({where, ".sticky"}, err_sticky, m_sticky);
        check({where, ".err_cnt"}, err_cnt, sat(n_err, 16));
        check({where, ".chk_cnt"}, chk_cnt, sat(n_chk, 16));
        check({where, ".s_sticky"}, s_sticky, m_sticky);
        check({where, ".s_err_cnt"}, s_err_cnt, sat(n_err, 4));
        check({where, ".s_chk_cnt"}, s_chk_cnt, sat(n_chk, 4));
    endtask

    // One bus cycle: the emulated BRAM answers last cycle's reads (xor ma/mb corrupts), then new
    // traffic is applied. Entered and left at the falling edge.
    task automatic step(input string where,
                        input bit wea, input logic [9:0] aa, input logic [35:0] wda,
                        input bit web, input logic [9:0] ab, input logic [35:0] wdb,
                        input logic [35:0] ma, input logic [35:0] mb);
        bit ok_a, ok_b;
        rd_a = m_pend_a ? (m_exp_a ^ ma) : rand36();
        rd_b = m_pend_b ? (m_exp_b ^ mb) : rand36();
        m_err_a = m_pend_a && (ma != 0);
        m_err_b = m_pend_b && (mb != 0);
        n_chk += longint'(m_pend_a) + longint'(m_pend_b);
        n_err += longint'(m_err_a) + longint'(m_err_b);
        if (m_err_a || m_err_b) m_sticky = 1;
        m_coll = wea && web && (aa == ab);

        // A port's data is predictable only if the other port leaves that word alone this cycle.
        ok_a = !(web && ab == aa);
        ok_b = !(wea && aa == ab);
`ifdef BRAM_SB_TRANSPARENT_EN
        m_pend_a = ok_a && (wea || sh_vld[aa]);
        m_exp_a  = wea ? wda : sh_mem[aa];
        m_pend_b = ok_b && (web || sh_vld[ab]);
        m_exp_b  = web ? wdb : sh_mem[ab];
`else
        m_pend_a = ok_a && !wea && sh_vld[aa];
        m_exp_a  = sh_mem[aa];
        m_pend_b = ok_b && !web && sh_vld[ab];
        m_exp_b  = sh_mem[ab];
`endif
        if (m_coll) begin
            sh_vld[aa] = 0;
        end else begin
            if (wea) begin sh_mem[aa] = wda; sh_vld[aa] = 1; end
            if (web) begin sh_mem[ab] = wdb; sh_vld[ab] = 1; end
        end

        a_a = aa; we_a = wea; wd_a = wda;
        a_b = ab; we_b = web; wd_b = wdb;
        @(posedge clk);
        @(negedge clk);
        $display("%s: A we=%0d a=%0h rd=%0h | B we=%0d a=%0h rd=%0h | err=%0d%0d coll=%0d chk=%0d errs=%0d",
                 where, wea, aa, rd_a, web, ab, rd_b, err_a, err_b, coll, chk_cnt, err_cnt);
        check_outputs(where);
    endtask

    task automatic idle(input string where, input logic [35:0] ma);
        step(where, 0, IDLE_ADR, '0, 0, IDLE_ADR, '0, ma, '0);
    endtask

    initial begin
        logic [15:0] c0;
        logic [9:0]  ra, rb;
        logic [35:0] ma, mb;
        bit          wa, wb;

        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;

        // Read of a never-written word is not compared.
        step("unwritten", 0, 10'h005, '0, 0, IDLE_ADR, '0, '0, '0);
        idle("unwritten_rsp", '0);
        check("unwritten.chk0", chk_cnt, 0);

        // Write then read back good data.
        step("wr5", 1, 10'h005, 36'h123456789, 0, IDLE_ADR, '0, '0, '0);
        step("rd5", 0, 10'h005, '0, 0, IDLE_ADR, '0, '0, '0);
        idle("rd5_rsp", '0);
`ifndef BRAM_SB_TRANSPARENT_EN
        check("rd5.chk1", chk_cnt, 1);
`endif
        check("rd5.noerr", err_a, 0);

        // Same read, BRAM returns 0x123456788.
        step("rd5b", 0, 10'h005, '0, 0, IDLE_ADR, '0, '0, '0);
        idle("rd5b_rsp", 36'h1);
        check("rd5b.err_a", err_a, 1);
        check("rd5b.sticky", err_sticky, 1);
`ifndef BRAM_SB_TRANSPARENT_EN
        check("rd5b.err_cnt1", err_cnt, 1);
`endif
        idle("rd5b_after", '0);
        check("rd5b.pulse_end", err_a, 0);

        // Collision on 0x3FF invalidates the word.
        step("coll", 1, 10'h3FF, 36'hA, 1, 10'h3FF, 36'hB, '0, '0);
        check("coll.pulse", coll, 1);
        c0 = chk_cnt;
        step("rd3ff", 0, 10'h3FF, '0, 0, IDLE_ADR, '0, '0, '0);
        idle("rd3ff_rsp", '0);
        check("rd3ff.unchecked", chk_cnt, c0);

        // Read while the other port overwrites: skipped; next read expects the new data.
        step("wrb10", 0, IDLE_ADR, '0, 1, 10'h010, 36'h55, '0, '0);
        step("rdwr10", 0, 10'h010, '0, 1, 10'h010, 36'h66, '0, '0);
        step("rd10", 0, 10'h010, '0, 0, IDLE_ADR, '0, '0, '0);
        c0 = chk_cnt;
        idle("rd10_rsp_old", 36'h66 ^ 36'h55);
        check("rd10.one_chk", chk_cnt, c0 + 16'd1);
        check("rd10.stale_flagged", err_a, 1);

        // Drive enough mismatches to saturate the 4-bit instance.
        step("wr1", 1, 10'h001, 36'h0F0F0F0F0, 0, IDLE_ADR, '0, '0, '0);
        for (int i = 0; i < 20; i++) step("sat", 0, 10'h001, '0, 0, IDLE_ADR, '0, 36'h1, '0);
        check("sat.s_err_cnt15", s_err_cnt, 4'd15);

        // Reset asserted mid-cycle while a compare is pending.
        rd_a = m_exp_a ^ 36'h1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge clk);
        @(negedge clk);
        check_outputs("in_rst");
        rst_n = 1'b1;
        idle("post_rst", 36'h1);
        check("post_rst.no_err", err_a, 0);
        check("post_rst.err_cnt0", err_cnt, 0);

        // Random traffic on a small address pool to get frequent hits and collisions.
        for (int i = 0; i < 600; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
            rb = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
            wa = ($urandom_range(0, 9) < 4);
            wb = ($urandom_range(0, 9) < 4);
            ma = ($urandom_range(0, 3) == 0) ? (36'h1 << $urandom_range(0, 35)) : 36'h0;
            mb = ($urandom_range(0, 3) == 0) ? (36'h1 << $urandom_range(0, 35)) : 36'h0;
            step("rand", wa, ra, rand36(), wb, rb, rand36(), ma, mb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
